stream_traffic_gen: RTL and testbench

- Programmable stream transmitter. Drives a valid/ready data stream into downstream buffering, e.g. the synchronous stream FIFO.
- Emits a configured number of beats, using either an incrementing pattern or an LFSR pattern, with optional idle gaps between beats.
- Reports progress, completion and back-pressure statistics.
- Used for bring-up, throughput characterisation and as the data source in stream-path testbenches.

---
 rtl/stream_traffic_gen.sv | 159 +++++++++++++++
 tb/tb_stream_traffic_gen.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_traffic_gen.sv
// Programmable valid/ready stream source. It sends cfg_len beats of an
// incrementing or Galois-LFSR pattern, with optional idle gaps between beats.
// It also reports busy/done status, the handshake count and the stall count.
module stream_traffic_gen #(
  parameter int unsigned DSIZE     = 32,
  parameter int unsigned LSIZE     = 16,
  parameter int unsigned GSIZE     = 8,
  parameter logic [31:0] LFSR_POLY = 32'h80200003
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LSIZE-1:0] cfg_len,
  input  logic [GSIZE-1:0] cfg_gap,
  input  logic             cfg_mode,
  input  logic [DSIZE-1:0] cfg_seed,
  output logic [DSIZE-1:0] dout_TDATA,
  output logic             dout_TVALID,
  input  logic             dout_TREADY,
  output logic             busy,
  output logic             done,
  output logic [LSIZE-1:0] sent_cnt,
  output logic [31:0]      stall_cnt
);

  localparam logic [DSIZE-1:0] Poly = DSIZE'(LFSR_POLY);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StFin} state_e;

  state_e           state_q, state_d;
  logic [DSIZE-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LSIZE-1:0] sent_q, sent_d;
  logic [31:0]      stall_q, stall_d;
  logic [LSIZE-1:0] rem_q, rem_d;
  logic [GSIZE-1:0] gap_cfg_q, gap_cfg_d;
  logic [GSIZE-1:0] gap_cnt_q, gap_cnt_d;
  logic             mode_q, mode_d;
  logic [DSIZE-1:0] data_next;

  // Next pattern word from the current one.
  always_comb begin
    if (mode_q) begin
      data_next = data_q[0] ? ((data_q >> 1) ^ Poly) : (data_q >> 1);
    end else begin
      data_next = data_q + DSIZE'(1);
    end
  end

  // Next-state and registered-output computation for the run FSM.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sent_d    = sent_q;
    stall_d   = stall_q;
    rem_d     = rem_q;
    gap_cfg_d = gap_cfg_q;
    gap_cnt_d = gap_cnt_q;
    mode_d    = mode_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          gap_cfg_d = cfg_gap;
          mode_d    = cfg_mode;
          sent_d    = '0;
          stall_d   = '0;
          rem_d     = cfg_len;
          // An all-zero LFSR state would lock up, so it is replaced by 1.
          data_d    = (cfg_mode && cfg_seed == '0) ? DSIZE'(1) : cfg_seed;
          if (cfg_len != '0) begin
            state_d = StSend;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = StFin;
            done_d  = 1'b1;
          end
        end
      end
      StSend: begin
        if (dout_TREADY) begin
          sent_d = sent_q + LSIZE'(1);
          rem_d  = rem_q - LSIZE'(1);
          data_d = data_next;
          if (rem_q == LSIZE'(1)) begin
            state_d = StFin;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (gap_cfg_q != '0) begin
            state_d   = StGap;
            valid_d   = 1'b0;
            gap_cnt_d = gap_cfg_q;
          end
        end else if (stall_q != '1) begin
          stall_d = stall_q + 32'd1;
        end
      end
      StGap: begin
        if (gap_cnt_q <= GSIZE'(1)) begin
          state_d = StSend;
          valid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GSIZE'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sent_q    <= '0;
      stall_q   <= '0;
      rem_q     <= '0;
      gap_cfg_q <= '0;
      gap_cnt_q <= '0;
      mode_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sent_q    <= sent_d;
      stall_q   <= stall_d;
      rem_q     <= rem_d;
      gap_cfg_q <= gap_cfg_d;
      gap_cnt_q <= gap_cnt_d;
      mode_q    <= mode_d;
    end
  end

  assign dout_TDATA  = data_q;
  assign dout_TVALID = valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sent_cnt    = sent_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_stream_traffic_gen.sv
// Self-checking bench for stream_traffic_gen: directed table runs, hand-written
// corner sequences and randomized runs against a timeline reference model.
module tb_stream_traffic_gen;

  localparam logic [31:0] Poly = 32'h80200003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] cfg_len;
  logic [7:0]  cfg_gap;
  logic        cfg_mode;
  logic [31:0] cfg_seed;
  logic [31:0] dout_TDATA;
  logic        dout_TVALID;
  logic        dout_TREADY;
  logic        busy;
  logic        done;
  logic [15:0] sent_cnt;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  stream_traffic_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_len    (cfg_len),
    .cfg_gap    (cfg_gap),
    .cfg_mode   (cfg_mode),
    .cfg_seed   (cfg_seed),
    .dout_TDATA (dout_TDATA),
    .dout_TVALID(dout_TVALID),
    .dout_TREADY(dout_TREADY),
    .busy       (busy),
    .done       (done),
    .sent_cnt   (sent_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // k-th word of a run, straight from the pattern rules.
  function automatic logic [31:0] pat(input logic [31:0] seed, input logic mode, input int k);
    logic [31:0] d;
    d = (mode && seed == 32'd0) ? 32'd1 : seed;
    for (int i = 0; i < k; i++) begin
      if (mode) d = d[0] ? ((d >> 1) ^ Poly) : (d >> 1);
      else      d = d + 32'd1;
    end
    return d;
  endfunction

  task automatic launch(input int len, input int gap, input logic mode, input logic [31:0] seed);
    cfg_len  = 16'(len);
    cfg_gap  = 8'(gap);
    cfg_mode = mode;
    cfg_seed = seed;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  typedef struct {
    int          len;
    int          gap;
    logic        mode;
    logic [31:0] seed;
    logic [31:0] exp [3];
  } vec_t;

  vec_t vecs [5];

  // Randomized run: the model tracks when the next beat may be shown
  // (handshake cycle + 1 + gap) and pops expected words from a queue.
  task automatic run_random(input int len, input int gap, input logic mode,
                            input logic [31:0] seed);
    logic [31:0] q [$];
    int cyc, next_valid, stalls, iter;
    logic exp_valid, rdy;
    for (int k = 0; k < len; k++) q.push_back(pat(seed, mode, k));
    launch(len, gap, mode, seed);
    cyc = 0; next_valid = 0; stalls = 0; iter = 0;
    while (q.size() > 0 && iter < 2000) begin
      exp_valid = (cyc >= next_valid);
      check("rnd_valid", 64'(dout_TVALID), 64'(exp_valid));
      if (exp_valid) check("rnd_data", 64'(dout_TDATA), 64'(q[0]));
      check("rnd_busy", 64'(busy), 64'd1);
      rdy = 1'($urandom_range(0, 1));
      dout_TREADY = rdy;
      if (exp_valid && rdy) begin
        void'(q.pop_front());
        next_valid = cyc + 1 + gap;
      end else if (exp_valid) begin
        stalls++;
      end
      tick();
      cyc++;
      iter++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL rnd_timeout: got %0d beats left, expected 0", q.size());
    end
    dout_TREADY = 1'b0;
    check("rnd_done", 64'(done), 64'd1);
    check("rnd_fin_valid", 64'(dout_TVALID), 64'd0);
    check("rnd_fin_busy", 64'(busy), 64'd0);
    check("rnd_sent", 64'(sent_cnt), 64'(len));
    check("rnd_stall", 64'(stall_cnt), 64'(stalls));
    tick();
    check("rnd_done_clr", 64'(done), 64'd0);
  endtask

  initial begin
    vecs[0] = '{len: 4, gap: 0, mode: 1'b0, seed: 32'h10,
                exp: '{32'h10, 32'h11, 32'h12}};
    vecs[1] = '{len: 3, gap: 0, mode: 1'b1, seed: 32'h1,
                exp: '{32'h00000001, 32'h80200003, 32'hC0300002}};
    vecs[2] = '{len: 3, gap: 2, mode: 1'b0, seed: 32'h5,
                exp: '{32'h5, 32'h6, 32'h7}};
    vecs[3] = '{len: 2, gap: 0, mode: 1'b1, seed: 32'h0,
                exp: '{32'h1, 32'h80200003, 32'h0}};
    vecs[4] = '{len: 3, gap: 1, mode: 1'b1, seed: 32'h80200003,
                exp: '{32'h80200003, 32'hC0300002, 32'h60180001}};

    rst_n = 1'b0; start = 1'b0; cfg_len = '0; cfg_gap = '0; cfg_mode = 1'b0;
    cfg_seed = '0; dout_TREADY = 1'b0;
    tick(); tick();
    check("rst_valid", 64'(dout_TVALID), 64'd0);
    check("rst_data", 64'(dout_TDATA), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sent", 64'(sent_cnt), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed table runs with the sink always ready.
    foreach (vecs[v]) begin
      dout_TREADY = 1'b1;
      launch(vecs[v].len, vecs[v].gap, vecs[v].mode, vecs[v].seed);
      for (int i = 0; i < vecs[v].len; i++) begin
        if (i > 0) begin
          for (int g = 0; g < vecs[v].gap; g++) begin
            check("tbl_gap_valid", 64'(dout_TVALID), 64'd0);
            check("tbl_gap_busy", 64'(busy), 64'd1);
            tick();
          end
        end
        check("tbl_valid", 64'(dout_TVALID), 64'd1);
        if (i < 3) check("tbl_data", 64'(dout_TDATA), 64'(vecs[v].exp[i]));
        else       check("tbl_data", 64'(dout_TDATA), 64'(vecs[v].seed + 32'(i)));
        tick();
      end
      dout_TREADY = 1'b0;
      check("tbl_done", 64'(done), 64'd1);
      check("tbl_fin_valid", 64'(dout_TVALID), 64'd0);
      check("tbl_sent", 64'(sent_cnt), 64'(vecs[v].len));
      check("tbl_stall", 64'(stall_cnt), 64'd0);
      tick();
      check("tbl_done_clr", 64'(done), 64'd0);
    end

    // Back-pressure with wrap from all-ones to zero.
    dout_TREADY = 1'b0;
    launch(2, 0, 1'b0, 32'hFFFFFFFF);
    for (int s = 0; s < 5; s++) begin
      check("bp_valid", 64'(dout_TVALID), 64'd1);
      check("bp_hold", 64'(dout_TDATA), 64'hFFFFFFFF);
      tick();
    end
    dout_TREADY = 1'b1;
    check("bp_hold_last", 64'(dout_TDATA), 64'hFFFFFFFF);
    tick();
    check("bp_wrap", 64'(dout_TDATA), 64'h0);
    check("bp_valid2", 64'(dout_TVALID), 64'd1);
    tick();
    dout_TREADY = 1'b0;
    check("bp_done", 64'(done), 64'd1);
    check("bp_stall", 64'(stall_cnt), 64'd5);
    check("bp_sent", 64'(sent_cnt), 64'd2);
    tick();

    // Zero-length run.
    launch(0, 0, 1'b0, 32'h55);
    check("zl_done", 64'(done), 64'd1);
    check("zl_valid", 64'(dout_TVALID), 64'd0);
    check("zl_busy", 64'(busy), 64'd0);
    check("zl_sent", 64'(sent_cnt), 64'd0);
    tick();
    check("zl_done_clr", 64'(done), 64'd0);

    // start during SEND must not disturb the run in progress.
    dout_TREADY = 1'b0;
    launch(3, 0, 1'b0, 32'h40);
    cfg_len = 16'd1; cfg_seed = 32'h99; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_data", 64'(dout_TDATA), 64'h40);
    dout_TREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("ign_beat", 64'(dout_TDATA), 64'(32'h40 + 32'(i)));
      check("ign_valid", 64'(dout_TVALID), 64'd1);
      tick();
    end
    dout_TREADY = 1'b0;
    check("ign_done", 64'(done), 64'd1);
    check("ign_sent", 64'(sent_cnt), 64'd3);
    check("ign_stall", 64'(stall_cnt), 64'd1);
    tick();

    // Reset mid-run aborts without a done pulse.
    dout_TREADY = 1'b1;
    launch(8, 0, 1'b0, 32'h0);
    tick(); tick();
    check("mr_sent2", 64'(sent_cnt), 64'd2);
    check("mr_data2", 64'(dout_TDATA), 64'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_valid", 64'(dout_TVALID), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_sent", 64'(sent_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("mr_no_done", 64'(done), 64'd0);
      check("mr_idle_valid", 64'(dout_TVALID), 64'd0);
      tick();
    end
    dout_TREADY = 1'b0;

    // Randomized runs against the reference model.
    for (int r = 0; r < 25; r++) begin
      logic [31:0] seed;
      seed = (r % 7 == 3) ? 32'd0 : $urandom;
      run_random($urandom_range(1, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)), seed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
